// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port RAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef logic port_t;

  localparam port_t PORT_IF = 1'b0;
  localparam port_t PORT_DM = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-way grant, round-robin or fixed priority.
// The history (last_grant) is owned by the caller so this block stays stateless.
module rr_arbiter2
  import mem_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // Sole requester wins; on a tie, port 0 under fixed priority, else the port not served last.
  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
      if ((FIXED_PRIO != 0) || (last_grant == PORT_DM)) grant = 2'b01;
      else                                              grant = 2'b10;
    end else if (valid0) begin
      grant = 2'b01;
    end else if (valid1) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM (async read, sync write) between the
// instruction-fetch port (0) and the load/store port (1). Every access takes
// three cycles: IDLE (arbitrate and accept), ACCESS (drive RAM), RESP (pulse).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [WIDTH-1:0]      req0_wdata,
  output logic                  resp0_valid,
  output logic [WIDTH-1:0]      resp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [WIDTH-1:0]      req1_wdata,
  output logic                  resp1_valid,
  output logic [WIDTH-1:0]      resp1_rdata,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata
);

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      wdata;
    port_t                 port;
  } cmd_t;

  state_t     state;
  cmd_t       cmd;
  cmd_t       next_cmd;
  logic       last_grant;
  logic [1:0] grant;
  logic       accepting;

  rr_arbiter2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // reset is active-low: readies are forced low while it is asserted even though state reads IDLE.
  assign accepting  = reset && (state == IDLE);
  assign req0_ready = accepting && grant[0];
  assign req1_ready = accepting && grant[1];

  // cmd.write is cleared on leaving ACCESS, so both terms only rise together and fall together.
  assign mem_write = (state == ACCESS) && cmd.write;
  assign mem_addr  = cmd.addr;
  assign mem_wdata = cmd.wdata;

  // Select the granted port's request fields as the candidate command.
  always_comb begin
    next_cmd.write = req0_write;
    next_cmd.addr  = req0_addr;
    next_cmd.wdata = req0_wdata;
    next_cmd.port  = PORT_IF;
    if (grant[1]) begin
      next_cmd.write = req1_write;
      next_cmd.addr  = req1_addr;
      next_cmd.wdata = req1_wdata;
      next_cmd.port  = PORT_DM;
    end
  end

  // Access sequencer: accept in IDLE, drive the RAM in ACCESS, pulse the response in RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cmd         <= '0;
      last_grant  <= PORT_DM;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp0_rdata <= '0;
      resp1_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            cmd        <= next_cmd;
            last_grant <= next_cmd.port;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          // The RAM commits a write at this same edge; mem_rdata still shows the old word.
          cmd.write <= 1'b0;
          if (cmd.port == PORT_IF) begin
            resp0_valid <= 1'b1;
            resp0_rdata <= mem_rdata;
          end else begin
            resp1_valid <= 1'b1;
            resp1_rdata <= mem_rdata;
          end
          state <= RESP;
        end
        RESP: begin
          resp0_valid <= 1'b0;
          resp1_valid <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
